// File: rtl/memory_arbiter.sv
// Purpose : round-robin arbiter sharing one block-wide main memory between the I-cache and D-cache.
// Latency : request sampled in IDLE -> strobe next edge; 3 cycles of overhead plus memory latency.
// Backpress: per-client BUSYWAIT stays high until that client's own DONE cycle; MEM_BUSYWAIT stalls WAIT.
//
// Ports:
//   CLK, RESET                    clock; asynchronous active-low reset
//   I_READ, I_ADDRESS             instruction-cache block read request
//   I_READDATA, I_BUSYWAIT        block returned to / stall for the instruction cache
//   D_READ, D_WRITE, D_ADDRESS,   data-cache block read / write-back request
//   D_WRITEDATA
//   D_READDATA, D_BUSYWAIT        block returned to / stall for the data cache
//   MEM_READ, MEM_WRITE,          registered memory request strobes, address and write block
//   MEM_ADDRESS, MEM_WRITEDATA
//   MEM_READDATA, MEM_BUSYWAIT    memory read block and busy indication
module memory_arbiter (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         I_READ,
  input  logic [27:0]  I_ADDRESS,
  output logic [127:0] I_READDATA,
  output logic         I_BUSYWAIT,
  input  logic         D_READ,
  input  logic         D_WRITE,
  input  logic [27:0]  D_ADDRESS,
  input  logic [127:0] D_WRITEDATA,
  output logic [127:0] D_READDATA,
  output logic         D_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Client encoding used by owner and last_grant.
  localparam logic CL_I = 1'b0;
  localparam logic CL_D = 1'b1;

  state_t         state_q,      state_d;
  logic           owner_q,      owner_d;
  logic           last_grant_q, last_grant_d;
  logic           mask_q,       mask_d;
  logic           op_write_q,   op_write_d;
  logic           mem_read_q,   mem_read_d;
  logic           mem_write_q,  mem_write_d;
  logic [27:0]    mem_addr_q,   mem_addr_d;
  logic [127:0]   mem_wdata_q,  mem_wdata_d;
  logic [127:0]   i_rdata_q,    i_rdata_d;
  logic [127:0]   d_rdata_q,    d_rdata_d;

  logic           i_req;
  logic           d_req;
  logic           i_elig;
  logic           d_elig;
  logic           grant_vld;
  logic           grant_cl;
  logic           grant_wr;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  // The client that just finished sits out the single IDLE cycle after DONE,
  // so a client that holds its request line through IDLE is not served twice.
  assign i_elig = i_req & ~(mask_q & (owner_q == CL_I));
  assign d_elig = d_req & ~(mask_q & (owner_q == CL_D));

  assign grant_vld = i_elig | d_elig;
  // On a tie the client that was not granted last time wins.
  assign grant_cl  = (i_elig & d_elig) ? ~last_grant_q : d_elig;
  // D_READ together with D_WRITE is a write-back.
  assign grant_wr  = (grant_cl == CL_D) & D_WRITE;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mask_d       = 1'b0;
    op_write_d   = op_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d      = grant_cl;
          last_grant_d = grant_cl;
          op_write_d   = grant_wr;
          mem_addr_d   = (grant_cl == CL_D) ? D_ADDRESS : I_ADDRESS;
          if (grant_cl == CL_D) begin
            mem_wdata_d = D_WRITEDATA;
          end
          // Strobes are registered here so they are visible while in ISSUE.
          mem_read_d   = ~grant_wr;
          mem_write_d  = grant_wr;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Memory has not seen the strobe yet, so its busy flag is meaningless here.
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = ST_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Read data is captured even if the owner has already dropped its request.
          if (!op_write_q) begin
            if (owner_q == CL_D) begin
              d_rdata_d = MEM_READDATA;
            end else begin
              i_rdata_d = MEM_READDATA;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        mask_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= CL_I;
      last_grant_q <= CL_I;
      mask_q       <= 1'b0;
      op_write_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mask_q       <= mask_d;
      op_write_q   <= op_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;

  // Only combinational output path: a requester is released solely in its own DONE cycle.
  assign I_BUSYWAIT = i_req & ~((state_q == ST_DONE) & (owner_q == CL_I));
  assign D_BUSYWAIT = d_req & ~((state_q == ST_DONE) & (owner_q == CL_D));

  a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET) !(MEM_READ && MEM_WRITE));

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that lets the pipelined CPU's instruction cache and data cache share one block-wide main memory. It sits between the caches (upstream clients) and the unified memory (downstream). It accepts one 128-bit block read or write at a time and serialises requests with round-robin priority. It returns per-client busywait and read data using the same handshake the memories already present to the caches.

## Interface
- CLK  input  1  clock, all state changes on rising edge
- RESET  input  1  asynchronous, active-low reset (0 = reset)
- I_READ  input  1  instruction-cache block read request
- I_ADDRESS  input  28  instruction block address
- I_READDATA  output  128  block returned to instruction cache
- I_BUSYWAIT  output  1  instruction client stall
- D_READ  input  1  data-cache block read request
- D_WRITE  input  1  data-cache block write (write-back) request
- D_ADDRESS  input  28  data block address
- D_WRITEDATA  input  128  block to write
- D_READDATA  output  128  block returned to data cache
- D_BUSYWAIT  output  1  data client stall
- MEM_READ / MEM_WRITE  output  1 each  memory request strobes
- MEM_ADDRESS  output  28  memory block address
- MEM_WRITEDATA  output  128  memory write block
- MEM_READDATA  input  128  memory read block
- MEM_BUSYWAIT  input  1  memory busy

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: owner (I/D), last_grant (I/D), latched op/address/writedata, I_READDATA, D_READDATA.
- Request definitions: D_req = D_READ | D_WRITE, and I_req = I_READ.
- If D_READ and D_WRITE are both high, the operation is a write.
- IDLE, when exactly one request is pending (after masking): grant that client.
- IDLE, when both requests are pending: grant the client other than last_grant.
- On grant: latch the address, op and writedata; set owner and last_grant; go to ISSUE.
- ISSUE: drive MEM_READ or MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA from the latches. MEM_BUSYWAIT is ignored in this state. Next state is WAIT.
- WAIT: keep driving the strobes. When MEM_BUSYWAIT is sampled 0, go to DONE. On a read, load MEM_READDATA into the owner's READDATA register at the same edge.
- DONE: deassert the memory strobes. Next state is IDLE.
- Completion mask: the owner just completed is not eligible for grant during the single IDLE cycle that follows DONE.
- X_BUSYWAIT = X_req & ~(state==DONE & owner==X). This is combinational, and is the only combinational output path.
- Memory strobes, address and writedata are registered.
- If the owner drops its request before DONE, the memory transaction still completes. READDATA is still updated. There is no abort.
- Non-owner READDATA registers hold their value.

## Timing
- Reset (RESET=0, asynchronous):
  - state=IDLE, last_grant=I (so D wins the first tie).
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - I_READDATA=D_READDATA=0.
  - BUSYWAITs equal their request inputs.
- Reset mid-transaction: the arbiter returns to IDLE immediately and the strobes drop. The memory recovers through its own reset.
- Request seen at IDLE at edge 0:
  - ISSUE from edge 1 (strobe visible).
  - WAIT from edge 2.
  - If MEM_BUSYWAIT is 0 at edge n (n≥3), then DONE in cycle n, client BUSYWAIT is low for that one cycle, and the state is IDLE at edge n+1.
  - Minimum client latency is 3 cycles of overhead plus memory latency.
- Back-to-back service: the next grant occurs at the IDLE edge following DONE. The strobes are low for at least 2 cycles between transactions (DONE, IDLE).
- A request arriving during a transaction is held with BUSYWAIT=1 until its own DONE.
- Widths are fixed; there is no address arithmetic.

## Test plan
- Reset, then I_READ, I_ADDRESS=28'h0000004, memory returns 128'hA5A5…A5 after 5 busy cycles:
  - MEM_READ high from edge 1.
  - I_BUSYWAIT low for exactly one cycle (DONE).
  - I_READDATA=128'hA5A5…A5.
  - D_READDATA stays 0.
- D_WRITE to 28'h0000010 with D_WRITEDATA=128'h1234…: MEM_WRITE=1, MEM_ADDRESS=28'h10 and MEM_WRITEDATA match; D_READDATA is unchanged.
- I_READ and D_READ asserted together immediately after reset:
  - D is served first.
  - I is granted at the IDLE edge after D's DONE.
  - Each BUSYWAIT falls only in its own DONE cycle.
- Both clients continuously requesting for 6 transactions: grants strictly alternate D,I,D,I,D,I, and no client is served twice in a row.
- RESET pulled low during WAIT of a D read: MEM_READ drops asynchronously, both READDATA registers=0, and the next request restarts from ISSUE.
- D_READ=D_WRITE=1: treated as a write (MEM_WRITE=1, MEM_READ=0).
- D drops its request mid-WAIT: the transaction still completes, D_READDATA is updated, and D_BUSYWAIT stays 0.
